// File: rtl/instruction_fetcher.sv
// Fetch stage: holds the PC, issues one icache request at a time, and queues the returned words for the decoder.
// Latency: a response accepted at edge R can issue to the decoder at edge R+1 at the earliest. There is no bypass.
// Backpressure: rob_full/rs_full/lsb_full stall dispatch. A full queue stops new requests. rdy_in=0 freezes all state.
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (global enable)
//   rob_full, rs_full, lsb_full : downstream occupancy; any one set blocks dispatch
//   rob_to_if_jump(_addr)       : redirect pulse and target; flushes the queue
//   if_to_ic_req/_addr          : one-cycle fetch request to the icache
//   ic_to_if_ready/_inst        : icache response pulse and instruction word
//   if_to_dc_ready/_PC/_inst/_opType : one-cycle issue pulse and its payload
module instruction_fetcher #(
  parameter int          IQ_DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_full,
  input  logic        rs_full,
  input  logic        lsb_full,
  input  logic        rob_to_if_jump,
  input  logic [31:0] rob_to_if_jump_addr,
  output logic        if_to_ic_req,
  output logic [31:0] if_to_ic_addr,
  input  logic        ic_to_if_ready,
  input  logic [31:0] ic_to_if_inst,
  output logic        if_to_dc_ready,
  output logic [31:0] if_to_dc_PC,
  output logic [31:0] if_to_dc_inst,
  output logic [6:0]  if_to_dc_opType
);

  localparam int PTR_W = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_STALL   = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic [1:0]       r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_q_pc   [IQ_DEPTH];
  logic [31:0]      r_q_inst [IQ_DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic        w_q_empty;
  logic        w_q_full;
  logic        w_enq;
  logic        w_deq;
  logic [6:0]  w_opcode;
  logic [31:0] w_jal_off;
  logic [31:0] w_next_pc;

  assign w_q_empty = (r_count == '0);
  assign w_q_full  = (r_count == CNT_W'(IQ_DEPTH));
  // A redirect wins over both queue operations in the same cycle.
  assign w_enq     = (r_state == S_WAIT) && ic_to_if_ready && !rob_to_if_jump;
  assign w_deq     = !w_q_empty && !rob_full && !rs_full && !lsb_full && !rob_to_if_jump;
  assign w_opcode  = ic_to_if_inst[6:0];
  // J-type immediate, sign-extended from bit 20 of the reassembled offset.
  assign w_jal_off = {{11{ic_to_if_inst[31]}}, ic_to_if_inst[31], ic_to_if_inst[19:12],
                      ic_to_if_inst[20], ic_to_if_inst[30:21], 1'b0};

  // Static prediction: JAL is taken at fetch. JALR holds the PC until the ROB redirects. Everything else falls through.
  always_comb begin
    w_next_pc = r_pc + 32'd4;
    if (w_opcode == OP_JAL) begin
      w_next_pc = r_pc + w_jal_off;
    end else if (w_opcode == OP_JALR) begin
      w_next_pc = r_pc;
    end
  end

  // The queue payload needs no reset. Validity is tracked by r_count and the pointers.
  always_ff @(posedge clk_in) begin
    if (rdy_in && w_enq) begin
      r_q_pc[r_tail]   <= r_pc;
      r_q_inst[r_tail] <= ic_to_if_inst;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state         <= S_IDLE;
      r_pc            <= RESET_PC;
      r_head          <= '0;
      r_tail          <= '0;
      r_count         <= '0;
      if_to_ic_req    <= 1'b0;
      if_to_ic_addr   <= 32'h0;
      if_to_dc_ready  <= 1'b0;
      if_to_dc_PC     <= 32'h0;
      if_to_dc_inst   <= 32'h0;
      if_to_dc_opType <= 7'h0;
    end else if (rdy_in) begin
      if_to_ic_req <= 1'b0;
      if (rob_to_if_jump) begin
        r_pc           <= rob_to_if_jump_addr;
        r_head         <= '0;
        r_tail         <= '0;
        r_count        <= '0;
        if_to_dc_ready <= 1'b0;
        case (r_state)
          // An unanswered request is still in flight and its data must be dropped.
          S_WAIT:    r_state <= ic_to_if_ready ? S_IDLE : S_DISCARD;
          S_DISCARD: r_state <= S_DISCARD;
          default:   r_state <= S_IDLE;
        endcase
      end else begin
        case (r_state)
          S_IDLE: begin
            if (!w_q_full) begin
              if_to_ic_req  <= 1'b1;
              if_to_ic_addr <= r_pc;
              r_state       <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (ic_to_if_ready) begin
              r_pc    <= w_next_pc;
              r_state <= (w_opcode == OP_JALR) ? S_STALL : S_IDLE;
            end
          end
          S_DISCARD: begin
            if (ic_to_if_ready) begin
              r_state <= S_IDLE;
            end
          end
          default: begin
            // STALL: only a redirect moves the fetcher on.
            r_state <= r_state;
          end
        endcase

        if (w_enq) begin
          r_tail <= r_tail + 1'b1;
        end

        if (w_deq) begin
          r_head          <= r_head + 1'b1;
          if_to_dc_ready  <= 1'b1;
          if_to_dc_PC     <= r_q_pc[r_head];
          if_to_dc_inst   <= r_q_inst[r_head];
          if_to_dc_opType <= r_q_inst[r_head][6:0];
        end else begin
          if_to_dc_ready <= 1'b0;
        end

        if (w_enq && !w_deq) begin
          r_count <= r_count + 1'b1;
        end else if (!w_enq && w_deq) begin
          r_count <= r_count - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher with a small icache responder and a decoder-side monitor.
// Requests and issues are logged with cycle stamps; each test checks them against hand-computed values.
module tb_instruction_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        rob_full = 1'b0;
  logic        rs_full = 1'b0;
  logic        lsb_full = 1'b0;
  logic        rob_to_if_jump = 1'b0;
  logic [31:0] rob_to_if_jump_addr = 32'h0;
  logic        if_to_ic_req;
  logic [31:0] if_to_ic_addr;
  logic        ic_to_if_ready = 1'b0;
  logic [31:0] ic_to_if_inst = 32'h0;
  logic        if_to_dc_ready;
  logic [31:0] if_to_dc_PC;
  logic [31:0] if_to_dc_inst;
  logic [6:0]  if_to_dc_opType;

  instruction_fetcher #(.IQ_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
    .rob_to_if_jump(rob_to_if_jump), .rob_to_if_jump_addr(rob_to_if_jump_addr),
    .if_to_ic_req(if_to_ic_req), .if_to_ic_addr(if_to_ic_addr),
    .ic_to_if_ready(ic_to_if_ready), .ic_to_if_inst(ic_to_if_inst),
    .if_to_dc_ready(if_to_dc_ready), .if_to_dc_PC(if_to_dc_PC),
    .if_to_dc_inst(if_to_dc_inst), .if_to_dc_opType(if_to_dc_opType)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [6:0]  op;
  } ev_t;

  ev_t         req_q[$];
  ev_t         iss_q[$];
  int          cyc = 0;
  int          ic_lat = 1;
  int          ic_cnt = 0;
  logic [31:0] ic_a = 32'h0;
  logic [31:0] mem_ovr [logic [31:0]];
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return 32'h00100093;
  endfunction

  // Icache responder and decoder monitor. Both sample at the edge, and the responder drives 1 time unit later.
  always @(posedge clk_in) begin
    logic        run;
    logic        fire;
    logic [31:0] a;
    ev_t         e;
    run  = rdy_in && !rst_in;
    fire = run && if_to_ic_req;
    a    = if_to_ic_addr;
    if (fire) begin
      e.cyc = cyc; e.pc = a; e.inst = 32'h0; e.op = 7'h0;
      req_q.push_back(e);
    end
    if (run && if_to_dc_ready) begin
      e.cyc = cyc; e.pc = if_to_dc_PC; e.inst = if_to_dc_inst; e.op = if_to_dc_opType;
      iss_q.push_back(e);
    end
    cyc = cyc + 1;
    #1;
    if (!run && rst_in) begin
      ic_cnt = 0;
      ic_to_if_ready = 1'b0;
    end else if (run) begin
      ic_to_if_ready = 1'b0;
      if (fire) begin
        ic_cnt = ic_lat;
        ic_a   = a;
      end
      if (ic_cnt > 0) begin
        ic_cnt = ic_cnt - 1;
        if (ic_cnt == 0) begin
          ic_to_if_ready = 1'b1;
          ic_to_if_inst  = mem_rd(ic_a);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic ev_t get_req(input int i);
    ev_t e;
    e = '{cyc: -1, pc: 32'hDEADBEEF, inst: 32'hDEADBEEF, op: 7'h7F};
    if (i < req_q.size()) e = req_q[i];
    return e;
  endfunction

  function automatic ev_t get_iss(input int i);
    ev_t e;
    e = '{cyc: -1, pc: 32'hDEADBEEF, inst: 32'hDEADBEEF, op: 7'h7F};
    if (i < iss_q.size()) e = iss_q[i];
    return e;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic wait_req(input int n, input int budget);
    for (int k = 0; k < budget && req_q.size() < n; k++) step(1);
  endtask

  task automatic wait_iss(input int n, input int budget);
    for (int k = 0; k < budget && iss_q.size() < n; k++) step(1);
  endtask

  task automatic do_reset();
    rst_in = 1'b1; rdy_in = 1'b1;
    rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
    rob_to_if_jump = 1'b0; rob_to_if_jump_addr = 32'h0;
    step(3);
    rst_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rb, ib, t0, ref0, ref5;
    logic [31:0] snap_pc, snap_addr;

    // Reset values
    step(3);
    check("rst_req", {31'h0, if_to_ic_req}, 32'h0);
    check("rst_addr", if_to_ic_addr, 32'h0);
    check("rst_dc_ready", {31'h0, if_to_dc_ready}, 32'h0);
    check("rst_dc_pc", if_to_dc_PC, 32'h0);
    check("rst_dc_inst", if_to_dc_inst, 32'h0);
    check("rst_dc_op", {25'h0, if_to_dc_opType}, 32'h0);

    // Sequential fetch with a 1-cycle icache
    ic_lat = 1; mem_ovr.delete();
    rb = req_q.size(); ib = iss_q.size();
    do_reset();
    wait_req(rb + 3, 60);
    wait_iss(ib + 3, 60);
    check("seq_req0", get_req(rb).pc, 32'h0);
    check("seq_req1", get_req(rb + 1).pc, 32'h4);
    check("seq_req2", get_req(rb + 2).pc, 32'h8);
    check("seq_iss0_pc", get_iss(ib).pc, 32'h0);
    check("seq_iss0_inst", get_iss(ib).inst, 32'h00100093);
    check("seq_iss0_op", {25'h0, get_iss(ib).op}, 32'h13);
    check("seq_iss1_pc", get_iss(ib + 1).pc, 32'h4);
    check("seq_latency", 32'(get_iss(ib).cyc - get_req(rb).cyc), 32'd3);
    check("seq_req_gap", 32'(get_req(rb + 1).cyc - get_req(rb).cyc), 32'd3);

    // JAL forward +0x20 at 0x10, and JAL backward -0x34 at 0x34
    mem_ovr.delete();
    mem_ovr[32'h10] = 32'h0200006F;
    mem_ovr[32'h34] = 32'hFCDFF06F;
    rb = req_q.size(); ib = iss_q.size();
    do_reset();
    wait_req(rb + 8, 100);
    wait_iss(ib + 6, 100);
    check("jal_req5", get_req(rb + 5).pc, 32'h30);
    check("jal_req6", get_req(rb + 6).pc, 32'h34);
    check("jal_back_req7", get_req(rb + 7).pc, 32'h0);
    check("jal_iss_pc", get_iss(ib + 4).pc, 32'h10);
    check("jal_iss_inst", get_iss(ib + 4).inst, 32'h0200006F);
    check("jal_iss_op", {25'h0, get_iss(ib + 4).op}, 32'h6F);
    check("jal_iss_next", get_iss(ib + 5).pc, 32'h30);

    // JALR at 0x8 stalls fetch; redirect flushes the queued 0,4,8
    mem_ovr.delete();
    mem_ovr[32'h8] = 32'h00008067;
    rb = req_q.size(); ib = iss_q.size();
    do_reset();
    rob_full = 1'b1;
    step(30);
    check("jalr_req_cnt", 32'(req_q.size() - rb), 32'd3);
    check("jalr_req2", get_req(rb + 2).pc, 32'h8);
    check("jalr_no_issue", 32'(iss_q.size() - ib), 32'd0);
    rob_to_if_jump = 1'b1; rob_to_if_jump_addr = 32'h100;
    step(1);
    rob_to_if_jump = 1'b0; rob_full = 1'b0;
    wait_req(rb + 4, 40);
    wait_iss(ib + 1, 40);
    check("jalr_redir_req", get_req(rb + 3).pc, 32'h100);
    check("jalr_flush_iss", get_iss(ib).pc, 32'h100);

    // Backpressure: queue fills to 4, then drains back to back
    mem_ovr.delete();
    rb = req_q.size(); ib = iss_q.size();
    do_reset();
    rob_full = 1'b1;
    step(40);
    check("bp_req_cnt", 32'(req_q.size() - rb), 32'd4);
    check("bp_no_issue", 32'(iss_q.size() - ib), 32'd0);
    check("bp_dc_ready", {31'h0, if_to_dc_ready}, 32'h0);
    rob_full = 1'b0;
    wait_iss(ib + 4, 40);
    wait_req(rb + 5, 40);
    for (int k = 0; k < 4; k++) check($sformatf("bp_iss%0d_pc", k), get_iss(ib + k).pc, 32'(4 * k));
    check("bp_b2b", 32'(get_iss(ib + 3).cyc - get_iss(ib).cyc), 32'd3);
    check("bp_req4", get_req(rb + 4).pc, 32'h10);

    // Asynchronous reset mid-operation clears outputs without a clock edge
    rst_in = 1'b1;
    #2;
    check("arst_dc_pc", if_to_dc_PC, 32'h0);
    check("arst_ic_addr", if_to_ic_addr, 32'h0);
    check("arst_dc_ready", {31'h0, if_to_dc_ready}, 32'h0);

    // Redirect while a 3-cycle icache response is pending
    ic_lat = 3; mem_ovr.delete();
    rb = req_q.size(); ib = iss_q.size();
    do_reset();
    wait_req(rb + 1, 20);
    rob_to_if_jump = 1'b1; rob_to_if_jump_addr = 32'h200;
    step(1);
    rob_to_if_jump = 1'b0;
    wait_req(rb + 2, 40);
    wait_iss(ib + 1, 40);
    check("disc_req0", get_req(rb).pc, 32'h0);
    check("disc_req1", get_req(rb + 1).pc, 32'h200);
    check("disc_iss0", get_iss(ib).pc, 32'h200);

    // rdy_in low for 3 cycles: the same run, shifted by exactly 3 cycles
    ic_lat = 1; mem_ovr.delete();
    ib = iss_q.size();
    do_reset();
    t0 = cyc;
    wait_iss(ib + 6, 80);
    ref0 = get_iss(ib).cyc - t0;
    ref5 = get_iss(ib + 5).cyc - t0;
    ib = iss_q.size();
    do_reset();
    t0 = cyc;
    step(8);
    rdy_in = 1'b0;
    snap_pc = if_to_dc_PC; snap_addr = if_to_ic_addr;
    step(3);
    check("frz_dc_pc", if_to_dc_PC, snap_pc);
    check("frz_ic_addr", if_to_ic_addr, snap_addr);
    rdy_in = 1'b1;
    wait_iss(ib + 6, 80);
    check("frz_iss0_cyc", 32'(get_iss(ib).cyc - t0), 32'(ref0));
    check("frz_iss5_cyc", 32'(get_iss(ib + 5).cyc - t0), 32'(ref5 + 3));
    check("frz_iss5_pc", get_iss(ib + 5).pc, 32'h14);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
